hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Consumes the control fields carried by the E/M and M/W control registers, from the reading side.
- Keeps its own shadow copy of destination-register and write-control state for the E, M and W stages.
- From that state it generates forwarding selects, stall and flush controls for the datapath pipeline registers.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset: state clears on a clk rising edge while reset==0.
- Rs1D  in  REG_ADDR_W  source register 1 of the instruction in D.
- Rs2D  in  REG_ADDR_W  source register 2 of the instruction in D.
- RdD  in  REG_ADDR_W  destination register of the instruction in D.
- RegWriteD  in  1  instruction in D writes the register file.
- ResultSrcD  in  2  result select of D (2'b01 = load from data memory).
- PCSrcE  in  1  branch/jump taken, resolved in E.
- ForwardAE  out  2  ALU operand A select: 00 regfile, 10 from M, 01 from W.
- ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE.
- StallF  out  1  hold the PC register.
- StallD  out  1  hold the F/D register.
- FlushD  out  1  clear the F/D register.
- FlushE  out  1  clear the D/E register.
- StallCount  out  CNT_W  load-use stall cycles (only with HAZARD_PERF_CNT_EN).
- FlushCount  out  CNT_W  branch flush events (only with HAZARD_PERF_CNT_EN).

Behaviour:
- Shadow state:
  - E stage: Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE.
  - M stage: RdM, RegWriteM.
  - W stage: RdW, RegWriteW.
- Reset (reset==0 at a clk edge): all shadow fields go to 0, so every stage holds a bubble (x0, no write). The outputs then evaluate to ForwardAE=ForwardBE=00 and StallF=StallD=FlushD=FlushE=0.
  - Reset mid-operation discards all tracked hazards.
  - Counters clear to 0.
- Shadow advance on each clk edge when reset==1:
  - If FlushE: the E stage loads a bubble (all fields 0).
  - Otherwise: the E stage loads the D fields (Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD).
  - M loads from E; W loads from M.
  - The stall decision (lwStall) does not hold E; it bubbles E through FlushE.
- Forwarding is combinational from the shadow state, with zero added latency:
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE = 00.
  - ForwardBE follows the same rules using Rs2E.
  - M has priority over W.
  - x0 is never forwarded.
- Load-use detection:
  - lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - StallF = StallD = lwStall.
- Flush controls:
  - FlushD = PCSrcE.
  - FlushE = lwStall || PCSrcE.
- Simultaneous lwStall and PCSrcE: all four controls assert. Clear has priority over enable in the downstream registers, so the F/D register clears.
- The stall condition lasts exactly 1 cycle per load-use pair, because the load advances to M on the next edge.
- Only ResultSrc==2'b01 is treated as a load; other encodings never stall.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - StallCount increments on each clk edge with lwStall==1.
  - FlushCount increments on each edge with PCSrcE==1.
  - Both counters saturate at all-ones and clear on reset.
- Not defined:
  - Counter ports and counter logic are absent.
  - Ports are declared under the same macro guard.

Decomposition:
- Shared package (riscv_pkg):
  - RESULT_SRC_ALU=2'b00, RESULT_SRC_MEM=2'b01, RESULT_SRC_PC4=2'b10.
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - REG_X0=0.
- One natural sub-module: fwd_sel. It is the combinational priority comparator for a single operand (Rs, RdM, RegWriteM, RdW, RegWriteW -> 2-bit select) and is instantiated twice.
- Shadow registers and counters stay in the top module.

Test Plan:
- Back-to-back ALU dependency: add x5 in D, then an instruction using x5 as Rs1, no load. Required: ForwardAE=10 in that E cycle; with one intervening instruction, ForwardAE=01.
- Same register in M and W: RdM=RdW=7, both writing, Rs2E=7. Required: ForwardBE=10 (M priority). With Rd=0 in both stages: ForwardBE=00.
- Load-use: lw x3 (ResultSrcD=01, RdD=3) followed by Rs1D=3. Required: StallF=StallD=FlushE=1 for exactly 1 cycle. The next cycle gives ForwardAE=01 with no stall.
- Taken branch: PCSrcE=1 for 1 cycle. Required: FlushD=FlushE=1 that cycle and StallF=0. The next E stage holds a bubble, so no forwarding from it.
- Reset mid-operation: load-use pending, reset=0 for 1 edge. Required: all outputs 0 the next cycle, and FlushCount=StallCount=0 with HAZARD_PERF_CNT_EN.
- Counters (HAZARD_PERF_CNT_EN): 3 load-use stalls and 2 taken branches. Required: StallCount=3, FlushCount=2. Preloading all-ones then another stall holds all-ones.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline encodings used by the hazard scoreboard and its forwarding comparators.
// The perf-counter option is controlled by the HAZARD_PERF_CNT_EN macro in hazard_scoreboard.
package riscv_pkg;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int REG_X0 = 0;

  // Only the data-memory result encoding counts as a load; the spare encoding never stalls.
  function automatic logic is_load(input logic [1:0] result_src);
    return result_src == RESULT_SRC_MEM;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_sel.sv
// Priority forwarding comparator for one ALU operand: M beats W, x0 is never forwarded.
module fwd_sel
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  output logic [1:0]            sel
);

  logic hit_m;
  logic hit_w;

  always_comb begin
    hit_m = reg_write_m && (rd_m != REG_ADDR_W'(REG_X0)) && (rd_m == rs);
    hit_w = reg_write_w && (rd_w != REG_ADDR_W'(REG_X0)) && (rd_w == rs);
    sel   = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shadows E/M/W write state and drives forward, stall and flush controls.
// Define HAZARD_PERF_CNT_EN to add the saturating StallCount/FlushCount performance counters.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  PCSrcE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
`endif
);

  if (CNT_W < 1 || REG_ADDR_W < 1) begin : g_bad_param
    $error("hazard_scoreboard: CNT_W and REG_ADDR_W must be at least 1");
  end

  logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
  logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
  logic [REG_ADDR_W-1:0] rd_e_q, rd_e_d;
  logic                  reg_write_e_q, reg_write_e_d;
  logic [1:0]            result_src_e_q, result_src_e_d;
  logic [REG_ADDR_W-1:0] rd_m_q, rd_m_d;
  logic                  reg_write_m_q, reg_write_m_d;
  logic [REG_ADDR_W-1:0] rd_w_q, rd_w_d;
  logic                  reg_write_w_q, reg_write_w_d;

  logic lw_stall;
  logic flush_e;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs          (rs1_e_q),
    .rd_m        (rd_m_q),
    .reg_write_m (reg_write_m_q),
    .rd_w        (rd_w_q),
    .reg_write_w (reg_write_w_q),
    .sel         (ForwardAE)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs          (rs2_e_q),
    .rd_m        (rd_m_q),
    .reg_write_m (reg_write_m_q),
    .rd_w        (rd_w_q),
    .reg_write_w (reg_write_w_q),
    .sel         (ForwardBE)
  );

  always_comb begin
    lw_stall = is_load(result_src_e_q)
               && (rd_e_q != REG_ADDR_W'(REG_X0))
               && ((rd_e_q == Rs1D) || (rd_e_q == Rs2D));
    flush_e  = lw_stall || PCSrcE;
    StallF   = lw_stall;
    StallD   = lw_stall;
    FlushD   = PCSrcE;
    FlushE   = flush_e;
  end

  // A load-use stall never holds E: the dependent instruction stays in D and E takes a bubble.
  always_comb begin
    rs1_e_d        = '0;
    rs2_e_d        = '0;
    rd_e_d         = '0;
    reg_write_e_d  = 1'b0;
    result_src_e_d = RESULT_SRC_ALU;
    if (!flush_e) begin
      rs1_e_d        = Rs1D;
      rs2_e_d        = Rs2D;
      rd_e_d         = RdD;
      reg_write_e_d  = RegWriteD;
      result_src_e_d = ResultSrcD;
    end
    rd_m_d        = rd_e_q;
    reg_write_m_d = reg_write_e_q;
    rd_w_d        = rd_m_q;
    reg_write_w_d = reg_write_m_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rs1_e_q        <= '0;
      rs2_e_q        <= '0;
      rd_e_q         <= '0;
      reg_write_e_q  <= 1'b0;
      result_src_e_q <= RESULT_SRC_ALU;
      rd_m_q         <= '0;
      reg_write_m_q  <= 1'b0;
      rd_w_q         <= '0;
      reg_write_w_q  <= 1'b0;
    end else begin
      rs1_e_q        <= rs1_e_d;
      rs2_e_q        <= rs2_e_d;
      rd_e_q         <= rd_e_d;
      reg_write_e_q  <= reg_write_e_d;
      result_src_e_q <= result_src_e_d;
      rd_m_q         <= rd_m_d;
      reg_write_m_q  <= reg_write_m_d;
      rd_w_q         <= rd_w_d;
      reg_write_w_q  <= reg_write_w_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (lw_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (PCSrcE && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random bench for hazard_scoreboard against a pipeline-of-instructions reference model.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic [1:0] rsrc;
  } instr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       PCSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] StallCount, FlushCount;
`endif

  hazard_scoreboard #(.REG_ADDR_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .ResultSrcD (ResultSrcD),
    .PCSrcE     (PCSrcE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount (StallCount),
    .FlushCount (FlushCount)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the instructions currently sitting in E, M and W.
  instr_t e_m, m_m, w_m, d_cur;
  logic   pc_cur;
  int     exp_stalls, exp_flushes;
  int     n_checks = 0;
  int     n_pass = 0;

  function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int we, input int rsrc);
    instr_t t;
    t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd); t.we = 1'(we); t.rsrc = 2'(rsrc);
    return t;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (m_m.we && m_m.rd == rs) return 2'b10;
    if (w_m.we && w_m.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_lw();
    return (e_m.rsrc == 2'b01) && (e_m.rd != 5'd0) && (e_m.rd == d_cur.rs1 || e_m.rd == d_cur.rs2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic apply(input instr_t d, input logic pc);
    d_cur = d; pc_cur = pc;
    Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd; RegWriteD = d.we; ResultSrcD = d.rsrc;
    PCSrcE = pc;
  endtask

  task automatic check_model();
    logic lw;
    @(negedge clk);
    lw = exp_lw();
    chk("ForwardAE", 32'(ForwardAE), 32'(exp_fwd(e_m.rs1)));
    chk("ForwardBE", 32'(ForwardBE), 32'(exp_fwd(e_m.rs2)));
    chk("StallF", 32'(StallF), 32'(lw));
    chk("StallD", 32'(StallD), 32'(lw));
    chk("FlushD", 32'(FlushD), 32'(pc_cur));
    chk("FlushE", 32'(FlushE), 32'(lw | pc_cur));
`ifdef HAZARD_PERF_CNT_EN
    chk("StallCount", 32'(StallCount), 32'(exp_stalls));
    chk("FlushCount", 32'(FlushCount), 32'(exp_flushes));
`endif
  endtask

  task automatic advance();
    logic lw;
    lw = exp_lw();
    @(posedge clk);
    if (!reset) begin
      e_m = '0; m_m = '0; w_m = '0;
      exp_stalls = 0; exp_flushes = 0;
    end else begin
      w_m = m_m;
      m_m = e_m;
      e_m = (lw || pc_cur) ? instr_t'(0) : d_cur;
      if (lw && exp_stalls < CNT_MAX) exp_stalls++;
      if (pc_cur && exp_flushes < CNT_MAX) exp_flushes++;
    end
    #1;
  endtask

  task automatic cyc(input instr_t d, input logic pc);
    apply(d, pc);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    advance();
    reset = 1'b1;
  endtask

  initial begin
    instr_t nop;
    nop = '0;
    e_m = '0; m_m = '0; w_m = '0;
    exp_stalls = 0; exp_flushes = 0;
    reset = 1'b0;
    apply(nop, 1'b0);
    @(posedge clk);
    advance();
    reset = 1'b1;

    // reset state
    apply(nop, 1'b0);
    check_model();
    chk("reset_outputs", 32'({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}), 32'd0);
    advance();

    // back-to-back ALU dependency on x5
    cyc(mk(1, 2, 5, 1, 0), 1'b0);
    cyc(mk(5, 6, 8, 1, 0), 1'b0);
    apply(nop, 1'b0); check_model();
    chk("alu_fwd_from_m", 32'(ForwardAE), 32'h2);
    advance();

    // one intervening instruction -> forward from W
    cyc(mk(1, 2, 9, 1, 0), 1'b0);
    cyc(mk(0, 0, 10, 1, 0), 1'b0);
    cyc(mk(9, 0, 11, 1, 0), 1'b0);
    apply(nop, 1'b0); check_model();
    chk("alu_fwd_from_w", 32'(ForwardAE), 32'h1);
    advance();

    // same register in M and W: M wins
    cyc(mk(0, 0, 7, 1, 0), 1'b0);
    cyc(mk(0, 0, 7, 1, 0), 1'b0);
    cyc(mk(0, 7, 12, 1, 0), 1'b0);
    apply(nop, 1'b0); check_model();
    chk("m_priority", 32'(ForwardBE), 32'h2);
    advance();

    // x0 in both stages is never forwarded
    cyc(mk(0, 0, 0, 1, 0), 1'b0);
    cyc(mk(0, 0, 0, 1, 0), 1'b0);
    cyc(mk(0, 0, 13, 1, 0), 1'b0);
    apply(nop, 1'b0); check_model();
    chk("x0_no_fwd", 32'(ForwardBE), 32'h0);
    advance();

    // load-use: exactly one stall cycle, then forward from W
    cyc(mk(0, 0, 3, 1, 1), 1'b0);
    apply(mk(3, 0, 4, 1, 0), 1'b0); check_model();
    chk("lw_stall_on", 32'({StallF, StallD, FlushE, FlushD}), 32'b1110);
    advance();
    apply(mk(3, 0, 4, 1, 0), 1'b0); check_model();
    chk("lw_stall_once", 32'(StallF), 32'h0);
    advance();
    apply(nop, 1'b0); check_model();
    chk("lw_fwd_w", 32'({ForwardAE, StallF}), 32'b010);
    advance();

    // non-load result encodings never stall
    cyc(mk(0, 0, 3, 1, 2), 1'b0);
    apply(mk(3, 3, 4, 1, 0), 1'b0); check_model();
    chk("pc4_no_stall", 32'(StallF), 32'h0);
    advance();

    // taken branch flushes D and E, next E is a bubble
    cyc(mk(0, 0, 14, 1, 0), 1'b0);
    apply(mk(14, 14, 15, 1, 0), 1'b1); check_model();
    chk("branch_flush", 32'({FlushD, FlushE, StallF}), 32'b110);
    advance();
    apply(nop, 1'b0); check_model();
    chk("branch_bubble", 32'({ForwardAE, ForwardBE}), 32'h0);
    advance();

    // simultaneous load-use and branch
    cyc(mk(0, 0, 6, 1, 1), 1'b0);
    apply(mk(6, 0, 2, 1, 0), 1'b1); check_model();
    chk("lw_and_branch", 32'({StallF, StallD, FlushD, FlushE}), 32'b1111);
    advance();

    // reset with a load-use pending
    cyc(mk(0, 0, 3, 1, 1), 1'b1);
    cyc(mk(0, 0, 3, 1, 1), 1'b0);
    apply(mk(3, 0, 4, 1, 0), 1'b0);
    do_reset();
    apply(mk(3, 0, 4, 1, 0), 1'b0); check_model();
    chk("mid_reset_outputs", 32'({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("mid_reset_counts", 32'({StallCount, FlushCount}), 32'd0);
`endif
    advance();

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(mk(0, 0, 3, 1, 1), 1'b0);
      cyc(mk(0, 3, 4, 1, 0), 1'b0);
      cyc(nop, 1'b0);
    end
    cyc(nop, 1'b1);
    cyc(nop, 1'b1);
    apply(nop, 1'b0); check_model();
    chk("stall_count_3", 32'(StallCount), 32'd3);
    chk("flush_count_2", 32'(FlushCount), 32'd2);
    advance();
    cyc(mk(0, 0, 3, 1, 1), 1'b0);
    cyc(mk(3, 0, 4, 1, 0), 1'b0);
    apply(nop, 1'b0); check_model();
    chk("stall_count_sat", 32'(StallCount), 32'(CNT_MAX));
    advance();
`endif

    // random traffic over a small register set to provoke collisions
    for (int i = 0; i < 400; i++) begin
      instr_t r;
      r = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        apply(r, 1'b0);
        check_model();
        do_reset();
      end else begin
        cyc(r, ($urandom_range(0, 7) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
